display_scan_sched: RTL and testbench

- Sequencer for the 4-digit seven-segment scan datapath.
- Generates the digit-select code and the BCD nibble for the currently driven digit from a slow refresh prescaler.
- Inserts anti-ghosting blank slots between digits, skips disabled digits, and latches the displayed value once per frame so it cannot tear mid-frame.
- Sits between the counter/BCD logic and the BCD-to-segment decoder.

---
 rtl/scan_pkg.sv | 46 ++++
 rtl/scan_tick_cnt.sv | 30 +++
 rtl/display_scan_sched.sv | 165 ++++++++++++++++
 tb/tb_display_scan_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Purpose: shared constants, state encoding and digit-search helper for the display scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int IDX_W      = 2;

    // All digit selects released (select lines are active-low).
    localparam logic [NUM_DIGITS-1:0] CTL_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // Next enabled digit strictly after cur, searching circularly.
    // If cur is the only enabled digit the search wraps back onto cur.
    // Passing cur = 3 yields the lowest enabled digit.
    function automatic logic [IDX_W-1:0] next_en_idx(
        input logic [NUM_DIGITS-1:0] mask,
        input logic [IDX_W-1:0]      cur
    );
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] c;
        logic             found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_DIGITS; i++) begin
            c = cur + IDX_W'(i);
            if (!found && mask[c]) begin
                res   = c;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Active-low one-cold select code for a digit index.
    function automatic logic [NUM_DIGITS-1:0] drive_code(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/scan_tick_cnt.sv
// Purpose: terminal-count slot timer; counts while enabled and wraps to zero at the terminal value.
// Latency: tc is combinational from the current count; count updates on the next edge.
// Backpressure: none; clr has priority over counting.
// Ports: clk/rst (sync, active-high), clr (force zero), en (count), term (terminal value),
//        tc (high while enabled and count == term).
module scan_tick_cnt #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic          tc
);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == term);

    // Wrap happens only through the terminal compare, never by overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_sched.sv
// Purpose: 4-digit seven-segment scan sequencer: blank slots between digit drives, skips disabled
//          digits, latches the displayed value once per frame. Optional macro SCAN_LZB_EN adds
//          leading-zero blanking.
// Latency: all outputs registered; one clk from a decision to its effect on ctl/out/frame_start.
// Backpressure: none; en=0 aborts to IDLE on the next edge, digit_en is sampled at slot decisions.
// Ports: clk, rst (sync active-high), en, digit_en[3:0], bcd_in[15:0] (nibble i = digit i),
//        ctl[3:0] (active-low digit select), out[3:0] (BCD of driven digit), frame_start (pulse).
module display_scan_sched
    import scan_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  digit_en,
    input  logic [15:0] bcd_in,
    output logic [3:0]  ctl,
    output logic [3:0]  out,
    output logic        frame_start
);

    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = $clog2((MAX_CYC < 2) ? 2 : MAX_CYC);
    localparam logic [CW-1:0] SCAN_TERM  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_TERM = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;
    localparam bit            HAS_BLANK  = (BLANK_CYC > 0);

    scan_state_t      state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] prev_idx;   // last digit actually driven
    logic             first_drv;  // next DRIVE is the first since IDLE
    logic [15:0]      shadow;

    logic             tc;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CW-1:0]    cnt_term;

    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic             go_drive;
    logic [IDX_W-1:0] drv_idx;
    logic             new_frame;
    logic [15:0]      shadow_nxt;
    logic [3:0]       drv_nib;
    logic [3:0]       drv_ctl;

    // One shared timer; its terminal value follows the slot type.
    assign cnt_term = (state == DRIVE) ? SCAN_TERM : BLANK_TERM;
    assign cnt_en   = (state != IDLE);
    assign cnt_clr  = (state == IDLE) || !en || ((state == DRIVE) && tc && (digit_en == 4'd0));

    scan_tick_cnt #(.CW(CW)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .term (cnt_term),
        .tc   (tc)
    );

    assign first_idx = next_en_idx(digit_en, IDX_W'(3));
    assign nxt_idx   = next_en_idx(digit_en, idx);

    // Entry into a DRIVE slot on this edge, which digit it drives, and whether it opens a frame.
    always_comb begin
        go_drive  = 1'b0;
        drv_idx   = idx;
        new_frame = 1'b0;
        case (state)
            IDLE: begin
                drv_idx   = first_idx;
                new_frame = 1'b1;
                go_drive  = !HAS_BLANK && en && (digit_en != 4'd0);
            end
            BLANK: begin
                drv_idx   = idx;
                new_frame = first_drv || (idx <= prev_idx);
                go_drive  = en && tc;
            end
            DRIVE: begin
                drv_idx   = nxt_idx;
                new_frame = (nxt_idx <= idx);
                go_drive  = !HAS_BLANK && en && tc && (digit_en != 4'd0);
            end
            default: ;
        endcase
    end

    // A frame-opening slot shows bcd_in directly while it is being captured.
    assign shadow_nxt = new_frame ? bcd_in : shadow;
    assign drv_nib    = shadow_nxt[{drv_idx, 2'b00} +: 4];

`ifdef SCAN_LZB_EN
    logic lead_zero;
    assign lead_zero = ((shadow_nxt >> {drv_idx, 2'b00}) == 16'd0);
    assign drv_ctl   = ((drv_idx != '0) && lead_zero) ? CTL_OFF : drive_code(drv_idx);
`else
    assign drv_ctl   = drive_code(drv_idx);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ctl         <= CTL_OFF;
            out         <= '0;
            frame_start <= 1'b0;
            idx         <= '0;
            prev_idx    <= '0;
            first_drv   <= 1'b0;
            shadow      <= '0;
        end else begin
            frame_start <= 1'b0;
            if ((state != IDLE) && !en) begin
                state <= IDLE;
                ctl   <= CTL_OFF;
                out   <= '0;
            end else if (go_drive) begin
                state       <= DRIVE;
                idx         <= drv_idx;
                prev_idx    <= drv_idx;
                first_drv   <= 1'b0;
                frame_start <= new_frame;
                if (new_frame) begin
                    shadow <= bcd_in;
                end
                ctl <= drv_ctl;
                out <= drv_nib;
            end else begin
                case (state)
                    IDLE: begin
                        ctl <= CTL_OFF;
                        out <= '0;
                        if (en && (digit_en != 4'd0)) begin
                            state     <= BLANK;
                            idx       <= first_idx;
                            first_drv <= 1'b1;
                        end
                    end
                    BLANK: ;
                    DRIVE: begin
                        if (tc) begin
                            ctl <= CTL_OFF;
                            out <= '0;
                            if (digit_en == 4'd0) begin
                                state <= IDLE;
                            end else begin
                                state <= BLANK;
                                idx   <= nxt_idx;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        ctl   <= CTL_OFF;
                        out   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_sched.sv
module tb_display_scan_sched;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  digit_en;
    logic [15:0] bcd_in;
    logic [3:0]  ctl0, out0, ctl1, out1;
    logic        fs0, fs1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Two builds side by side: with a 2-cycle blank gap and with no gap.
    display_scan_sched #(.SCAN_DIV(SD), .BLANK_CYC(2)) dut_gap (
        .clk(clk), .rst(rst), .en(en), .digit_en(digit_en), .bcd_in(bcd_in),
        .ctl(ctl0), .out(out0), .frame_start(fs0)
    );

    display_scan_sched #(.SCAN_DIV(SD), .BLANK_CYC(0)) dut_nogap (
        .clk(clk), .rst(rst), .en(en), .digit_en(digit_en), .bcd_in(bcd_in),
        .ctl(ctl1), .out(out1), .frame_start(fs1)
    );

    // Reference model: per build, what the display is doing and how many cycles remain.
    localparam int DARK = 0, GAP = 1, SHOW = 2;
    int          m_mode  [2];
    int          m_left  [2];
    int          m_cur   [2];
    int          m_last  [2];
    bit          m_first [2];
    logic [15:0] m_shadow[2];
    logic [3:0]  m_ctl   [2];
    logic [3:0]  m_out   [2];
    logic        m_fs    [2];

    logic [17:0] exp_q[$];

    function automatic int gap_len(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int next_on(input logic [3:0] mask, input int from);
        for (int k = 1; k <= 4; k++)
            if (mask[(from + k) % 4]) return (from + k) % 4;
        return from;
    endfunction

    function automatic void lights_off(input int d);
        m_ctl[d] = 4'hF;
        m_out[d] = 4'h0;
    endfunction

    function automatic void show(input int d);
        logic fr;
        fr = m_first[d] || (m_cur[d] <= m_last[d]);
        if (fr) m_shadow[d] = bcd_in;
        m_first[d] = 1'b0;
        m_last[d]  = m_cur[d];
        m_left[d]  = SD;
        m_mode[d]  = SHOW;
        m_fs[d]    = fr;
        m_out[d]   = m_shadow[d][4*m_cur[d] +: 4];
        m_ctl[d]   = 4'hF;
        m_ctl[d][m_cur[d]] = 1'b0;
`ifdef SCAN_LZB_EN
        if (m_cur[d] > 0 && (m_shadow[d] >> (4*m_cur[d])) == 16'd0) m_ctl[d] = 4'hF;
`endif
    endfunction

    function automatic void step(input int d);
        m_fs[d] = 1'b0;
        if (rst) begin
            m_mode[d] = DARK; m_shadow[d] = 16'd0; m_cur[d] = 0; m_last[d] = 0;
            lights_off(d);
        end else if (m_mode[d] != DARK && !en) begin
            m_mode[d] = DARK;
            lights_off(d);
        end else begin
            case (m_mode[d])
                DARK: begin
                    lights_off(d);
                    if (en && digit_en != 4'd0) begin
                        m_cur[d]   = next_on(digit_en, 3);
                        m_first[d] = 1'b1;
                        if (gap_len(d) > 0) begin m_mode[d] = GAP; m_left[d] = gap_len(d); end
                        else show(d);
                    end
                end
                GAP: begin
                    m_left[d]--;
                    if (m_left[d] == 0) show(d);
                end
                default: begin
                    m_left[d]--;
                    if (m_left[d] == 0) begin
                        if (digit_en == 4'd0) begin
                            m_mode[d] = DARK;
                            lights_off(d);
                        end else begin
                            m_cur[d] = next_on(digit_en, m_cur[d]);
                            if (gap_len(d) > 0) begin
                                m_mode[d] = GAP; m_left[d] = gap_len(d); lights_off(d);
                            end else show(d);
                        end
                    end
                end
            endcase
        end
    endfunction

    // One clock: the model consumes the same inputs the DUTs sample, expectation is queued.
    task automatic tick();
        @(posedge clk);
        step(0);
        step(1);
        exp_q.push_back({m_ctl[1], m_out[1], m_fs[1], m_ctl[0], m_out[0], m_fs[0]});
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] b;
        for (int i = 0; i < 4; i++)
            b[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
        return b;
    endfunction

    // Monitor: every cycle the DUTs present a new registered output; compare away from posedge.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({ctl0, out0, fs0} !== e[8:0]) begin
                    n_fail++;
                    $display("FAIL gap_build t=%0t ctl/out/fs got %b/%h/%b want %b/%h/%b",
                             $time, ctl0, out0, fs0, e[8:5], e[4:1], e[0]);
                end
                n_tests++;
                if ({ctl1, out1, fs1} !== e[17:9]) begin
                    n_fail++;
                    $display("FAIL nogap_build t=%0t ctl/out/fs got %b/%h/%b want %b/%h/%b",
                             $time, ctl1, out1, fs1, e[17:14], e[13:10], e[9]);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; en = 1'b0; digit_en = 4'd0; bcd_in = 16'd0;
        run(3);
        rst = 1'b0;
        run(2);

        // Two low digits.
        en = 1'b1; digit_en = 4'b0011; bcd_in = 16'h0042;
        run(30);
        // New value mid-frame must only appear at the next frame start.
        bcd_in = 16'h0055;
        run(20);
        // Sparse enables: digits 1 and 3 only.
        digit_en = 4'b1010; bcd_in = 16'h9070;
        run(30);
        // All four digits.
        digit_en = 4'b1111; bcd_in = 16'h4321;
        run(40);

        // Drop en for one cycle while a digit is lit, then restart.
        guard = 0;
        while (ctl0 == 4'hF && guard < 20) begin tick(); guard++; end
        n_tests++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL find_drive_slot waited %0d cycles, limit 20", guard);
        end
        tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        run(20);

        // Leading zeros.
        bcd_in = 16'h0030;
        run(40);
        // Single digit, then all digits disabled at a decision.
        digit_en = 4'b0100; bcd_in = 16'h0800;
        run(25);
        digit_en = 4'b0000;
        run(12);
        digit_en = 4'b1001;
        run(15);
        // Reset in the middle of a slot.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(20);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            en  = ($urandom_range(0, 40) != 0);
            if ($urandom_range(0, 31) == 0) digit_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bcd_in = rand_bcd();
            tick();
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain left %0d entries, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
